// File: rtl/spi_reg_pkg.sv
// Shared address map, field positions and register decode for the SPI register block.
// Address match is a full 32-bit compare, so aliases above 0x10 are unmapped.
package spi_reg_pkg;

  localparam logic [31:0] ADDR_TX_DATA = 32'h0000_0000;
  localparam logic [31:0] ADDR_RX_DATA = 32'h0000_0004;
  localparam logic [31:0] ADDR_CFG     = 32'h0000_0008;
  localparam logic [31:0] ADDR_CTRL    = 32'h0000_000C;
  localparam logic [31:0] ADDR_STT     = 32'h0000_0010;

  localparam int CFG_CPOL     = 0;
  localparam int CFG_CPHA     = 1;
  localparam int CFG_ORDER    = 2;
  localparam int CFG_SCKS_LO  = 3;
  localparam int CFG_SLAVE_LO = 5;
  localparam int CFG_W        = 9;

  localparam int CTRL_START = 0;
  localparam int CTRL_RD    = 1;
  localparam int STT_BUSY   = 0;

  typedef enum logic [2:0] {
    REG_TX_DATA,
    REG_RX_DATA,
    REG_CFG,
    REG_CTRL,
    REG_STT,
    REG_NONE
  } reg_idx_t;

  function automatic reg_idx_t decode(input logic [31:0] addr);
    reg_idx_t idx;
    case (addr)
      ADDR_TX_DATA: idx = REG_TX_DATA;
      ADDR_RX_DATA: idx = REG_RX_DATA;
      ADDR_CFG:     idx = REG_CFG;
      ADDR_CTRL:    idx = REG_CTRL;
      ADDR_STT:     idx = REG_STT;
      default:      idx = REG_NONE;
    endcase
    return idx;
  endfunction

  function automatic logic writable(input reg_idx_t idx);
    return (idx == REG_TX_DATA) || (idx == REG_CFG) || (idx == REG_CTRL);
  endfunction

endpackage

// File: rtl/register_block.sv
// SPI control/status register file: acks, errors and rdata appear one cycle after the request.
// No backpressure: every wr_en/rd_en cycle is accepted and acknowledged on the next cycle.
module register_block
  import spi_reg_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] waddr,
  input  logic [31:0] wdata,
  input  logic        wr_en,
  input  logic [31:0] raddr,
  input  logic        rd_en,
  output logic [31:0] rdata,
  output logic        wack,
  output logic        rack,
  output logic        waddrerr,
  output logic        raddrerr,
  output logic [31:0] tx_data,
  output logic        ctrl_cpol,
  output logic        ctrl_cpha,
  output logic        ctrl_order,
  output logic [1:0]  ctrl_scks,
  output logic [3:0]  ctrl_slave_en,
  output logic        ctrl_rd,
  output logic        start_op,
  input  logic [31:0] rx_data,
  input  logic        busy
);

  logic [7:0]       tx_q;
  logic [CFG_W-1:0] cfg_q;
  logic             rd_q;
  reg_idx_t         widx;
  reg_idx_t         ridx;
  logic [31:0]      rd_val;
  logic             unused_wdata;

  assign widx = decode(waddr);
  assign ridx = decode(raddr);
  assign unused_wdata = ^wdata[31:CFG_W];

  // Read mux sees pre-write state, so a same-cycle write to the read target is not visible.
  always_comb begin
    rd_val = '0;
    case (ridx)
      REG_TX_DATA: rd_val = {24'b0, tx_q};
      REG_RX_DATA: rd_val = rx_data;
      REG_CFG:     rd_val = {{(32-CFG_W){1'b0}}, cfg_q};
      REG_CTRL:    rd_val[CTRL_RD] = rd_q;
      REG_STT:     rd_val[STT_BUSY] = busy;
      default:     rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_q     <= '0;
      cfg_q    <= '0;
      rd_q     <= 1'b0;
      rdata    <= '0;
      wack     <= 1'b0;
      rack     <= 1'b0;
      waddrerr <= 1'b0;
      raddrerr <= 1'b0;
      start_op <= 1'b0;
    end else begin
      wack     <= wr_en;
      waddrerr <= wr_en && !writable(widx);
      rack     <= rd_en;
      raddrerr <= rd_en && (ridx == REG_NONE);
      start_op <= 1'b0;
      if (wr_en) begin
        case (widx)
          REG_TX_DATA: tx_q  <= wdata[7:0];
          REG_CFG:     cfg_q <= wdata[CFG_W-1:0];
          REG_CTRL: begin
            rd_q     <= wdata[CTRL_RD];
            // A start request while the core is busy is silently dropped.
            start_op <= wdata[CTRL_START] && !busy;
          end
          default: ;
        endcase
      end
      if (rd_en) rdata <= rd_val;
    end
  end

  assign tx_data       = {24'b0, tx_q};
  assign ctrl_cpol     = cfg_q[CFG_CPOL];
  assign ctrl_cpha     = cfg_q[CFG_CPHA];
  assign ctrl_order    = cfg_q[CFG_ORDER];
  assign ctrl_scks     = cfg_q[CFG_SCKS_LO +: 2];
  assign ctrl_slave_en = cfg_q[CFG_SLAVE_LO +: 4];
  assign ctrl_rd       = rd_q;

endmodule

// File: tb/tb_register_block.sv
// Bench for register_block: directed vector table, reset/pulse sequences, then random traffic vs a model.
module tb_register_block;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] waddr, wdata, raddr, rx_data;
  logic        wr_en, rd_en, busy;
  logic [31:0] rdata, tx_data;
  logic        wack, rack, waddrerr, raddrerr;
  logic        ctrl_cpol, ctrl_cpha, ctrl_order, ctrl_rd, start_op;
  logic [1:0]  ctrl_scks;
  logic [3:0]  ctrl_slave_en;

  int pass_cnt = 0;
  int total_cnt = 0;

  register_block dut (
    .clk(clk), .reset(reset),
    .waddr(waddr), .wdata(wdata), .wr_en(wr_en),
    .raddr(raddr), .rd_en(rd_en),
    .rdata(rdata), .wack(wack), .rack(rack),
    .waddrerr(waddrerr), .raddrerr(raddrerr),
    .tx_data(tx_data),
    .ctrl_cpol(ctrl_cpol), .ctrl_cpha(ctrl_cpha), .ctrl_order(ctrl_order),
    .ctrl_scks(ctrl_scks), .ctrl_slave_en(ctrl_slave_en), .ctrl_rd(ctrl_rd),
    .start_op(start_op), .rx_data(rx_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr_en;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        rd_en;
    logic [31:0] raddr;
    logic        busy;
    logic [31:0] rx_data;
    logic        e_wack;
    logic        e_werr;
    logic        e_rack;
    logic        e_rerr;
    logic [31:0] e_rdata;
    logic        e_start;
    logic [7:0]  e_tx;
    logic [8:0]  e_cfg;
    logic        e_crd;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [8:0] cfg_obs();
    return {ctrl_slave_en, ctrl_scks, ctrl_order, ctrl_cpha, ctrl_cpol};
  endfunction

  task automatic drive(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                       input logic re, input logic [31:0] ra, input logic bz, input logic [31:0] rx);
    wr_en = we; waddr = wa; wdata = wd; rd_en = re; raddr = ra; busy = bz; rx_data = rx;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic e_wack, input logic e_werr,
                           input logic e_rack, input logic e_rerr, input logic [31:0] e_rdata,
                           input logic e_start, input logic [7:0] e_tx, input logic [8:0] e_cfg,
                           input logic e_crd);
    check({tag, " wack"},     32'(wack),     32'(e_wack));
    check({tag, " waddrerr"}, 32'(waddrerr), 32'(e_werr));
    check({tag, " rack"},     32'(rack),     32'(e_rack));
    check({tag, " raddrerr"}, 32'(raddrerr), 32'(e_rerr));
    check({tag, " rdata"},    rdata,         e_rdata);
    check({tag, " start_op"}, 32'(start_op), 32'(e_start));
    check({tag, " tx_data"},  tx_data,       32'(e_tx));
    check({tag, " cfg"},      32'(cfg_obs()), 32'(e_cfg));
    check({tag, " ctrl_rd"},  32'(ctrl_rd),  32'(e_crd));
  endtask

  // Behavioural reference state for the random phase.
  logic [7:0]  m_tx;
  logic [8:0]  m_cfg;
  logic        m_rd;
  logic [31:0] m_rdata;

  function automatic logic mapped(input logic [31:0] a);
    return (a <= 32'h10) && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic bz, input logic [31:0] rx);
    if (!mapped(a)) return 32'h0;
    case (a / 4)
      0:       return {24'h0, m_tx};
      1:       return rx;
      2:       return {23'h0, m_cfg};
      3:       return {30'h0, m_rd, 1'b0};
      default: return {31'h0, bz};
    endcase
  endfunction

  function automatic logic [31:0] pick_addr();
    int k = int'($urandom_range(0, 7));
    if (k <= 4) return 32'(k * 4);
    if (k == 5) return 32'(k * 4) + 32'($urandom_range(1, 3));
    return $urandom;
  endfunction

  initial begin
    //          we  waddr     wdata         re  raddr     bz  rx            wack werr rack rerr rdata         st  tx     cfg     crd
    vecs[0]  = '{1, 32'h0,   32'hA5,       0, 32'h0,   0, 32'h0,        1, 0, 0, 0, 32'h0,        0, 8'hA5, 9'h000, 0};
    vecs[1]  = '{0, 32'h0,   32'h0,        1, 32'h0,   0, 32'h0,        0, 0, 1, 0, 32'hA5,       0, 8'hA5, 9'h000, 0};
    vecs[2]  = '{1, 32'h8,   32'h1FF,      0, 32'h0,   0, 32'h0,        1, 0, 0, 0, 32'hA5,       0, 8'hA5, 9'h1FF, 0};
    vecs[3]  = '{0, 32'h0,   32'h0,        1, 32'h8,   0, 32'h0,        0, 0, 1, 0, 32'h1FF,      0, 8'hA5, 9'h1FF, 0};
    vecs[4]  = '{1, 32'hC,   32'h1,        0, 32'h0,   0, 32'h0,        1, 0, 0, 0, 32'h1FF,      1, 8'hA5, 9'h1FF, 0};
    vecs[5]  = '{0, 32'h0,   32'h0,        1, 32'hC,   0, 32'h0,        0, 0, 1, 0, 32'h0,        0, 8'hA5, 9'h1FF, 0};
    vecs[6]  = '{1, 32'hC,   32'h1,        0, 32'h0,   1, 32'h0,        1, 0, 0, 0, 32'h0,        0, 8'hA5, 9'h1FF, 0};
    vecs[7]  = '{0, 32'h0,   32'h0,        1, 32'h4,   0, 32'hDEADBEEF, 0, 0, 1, 0, 32'hDEADBEEF, 0, 8'hA5, 9'h1FF, 0};
    vecs[8]  = '{0, 32'h0,   32'h0,        1, 32'h10,  1, 32'h0,        0, 0, 1, 0, 32'h1,        0, 8'hA5, 9'h1FF, 0};
    vecs[9]  = '{1, 32'hFF,  32'h12345678, 0, 32'h0,   0, 32'h0,        1, 1, 0, 0, 32'h1,        0, 8'hA5, 9'h1FF, 0};
    vecs[10] = '{0, 32'h0,   32'h0,        1, 32'hFF,  0, 32'h0,        0, 0, 1, 1, 32'h0,        0, 8'hA5, 9'h1FF, 0};
    vecs[11] = '{1, 32'h4,   32'h5,        0, 32'h0,   0, 32'h0,        1, 1, 0, 0, 32'h0,        0, 8'hA5, 9'h1FF, 0};
    vecs[12] = '{1, 32'h10,  32'hFFFFFFFF, 0, 32'h0,   0, 32'h0,        1, 1, 0, 0, 32'h0,        0, 8'hA5, 9'h1FF, 0};
    vecs[13] = '{1, 32'h100, 32'h77,       0, 32'h0,   0, 32'h0,        1, 1, 0, 0, 32'h0,        0, 8'hA5, 9'h1FF, 0};
    vecs[14] = '{1, 32'h0,   32'h3C,       1, 32'h0,   0, 32'h0,        1, 0, 1, 0, 32'hA5,       0, 8'h3C, 9'h1FF, 0};
    vecs[15] = '{0, 32'h0,   32'h0,        0, 32'h0,   0, 32'h0,        0, 0, 0, 0, 32'hA5,       0, 8'h3C, 9'h1FF, 0};
    vecs[16] = '{1, 32'hC,   32'h3,        1, 32'hC,   0, 32'h0,        1, 0, 1, 0, 32'h0,        1, 8'h3C, 9'h1FF, 1};
    vecs[17] = '{0, 32'h0,   32'h0,        1, 32'hC,   0, 32'h0,        0, 0, 1, 0, 32'h2,        0, 8'h3C, 9'h1FF, 1};
    vecs[18] = '{0, 32'h0,   32'h0,        1, 32'h10,  0, 32'hFFFFFFFF, 0, 0, 1, 0, 32'h0,        0, 8'h3C, 9'h1FF, 1};

    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    check_all("reset", 0, 0, 0, 0, 32'h0, 0, 8'h0, 9'h0, 0);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].wr_en, vecs[i].waddr, vecs[i].wdata, vecs[i].rd_en, vecs[i].raddr,
            vecs[i].busy, vecs[i].rx_data);
      check_all($sformatf("vec%0d", i), vecs[i].e_wack, vecs[i].e_werr, vecs[i].e_rack,
                vecs[i].e_rerr, vecs[i].e_rdata, vecs[i].e_start, vecs[i].e_tx,
                vecs[i].e_cfg, vecs[i].e_crd);
    end

    // Back-to-back start writes each produce their own pulse, then the pulse drops.
    drive(1, 32'hC, 32'h1, 0, 0, 0, 0);
    check("b2b start0", 32'(start_op), 32'h1);
    drive(1, 32'hC, 32'h1, 0, 0, 0, 0);
    check("b2b start1", 32'(start_op), 32'h1);
    check("b2b wack1", 32'(wack), 32'h1);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("b2b start idle", 32'(start_op), 32'h0);
    check("b2b wack idle", 32'(wack), 32'h0);

    // Requests coincident with reset are discarded and all state clears.
    reset = 1'b0;
    drive(1, 32'h8, 32'h0AA, 1, 32'h0, 0, 0);
    check_all("reset req", 0, 0, 0, 0, 32'h0, 0, 8'h0, 9'h0, 0);
    reset = 1'b1;

    m_tx = 8'h0; m_cfg = 9'h0; m_rd = 1'b0; m_rdata = 32'h0;
    for (int c = 0; c < 400; c++) begin
      logic        we, re, bz;
      logic [31:0] wa, wd, ra, rx;
      logic        e_start;
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      bz = 1'($urandom_range(0, 1));
      wa = pick_addr();
      ra = pick_addr();
      wd = $urandom;
      rx = $urandom;
      if (re) m_rdata = model_read(ra, bz, rx);
      e_start = 1'b0;
      if (we && mapped(wa)) begin
        if (wa == 32'h0) m_tx = wd[7:0];
        if (wa == 32'h8) m_cfg = wd[8:0];
        if (wa == 32'hC) begin
          m_rd = wd[1];
          e_start = wd[0] && !bz;
        end
      end
      drive(we, wa, wd, re, ra, bz, rx);
      check_all($sformatf("rnd%0d", c), we,
                we && !(mapped(wa) && (wa == 32'h0 || wa == 32'h8 || wa == 32'hC)),
                re, re && !mapped(ra), m_rdata, e_start, m_tx, m_cfg, m_rd);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/register_block.md
REGISTER_BLOCK -- requirements
Module: register_block

Interface
REQ-001 SHALL have no parameters; address map and field layout are fixed constants.
REQ-002 SHALL use a single clock and a synchronous, active-low reset; ports are named clk and reset.
REQ-003 clk  input  1  rising-edge system clock.
REQ-004 reset  input  1  synchronous active-low reset.
REQ-005 waddr  input  32  write byte address.
REQ-006 wdata  input  32  write data.
REQ-007 wr_en  input  1  write request, sampled each cycle.
REQ-008 raddr  input  32  read byte address.
REQ-009 rd_en  input  1  read request, sampled each cycle.
REQ-010 rdata  output  32  registered read data.
REQ-011 wack / rack  output  1 each  one-cycle write / read acknowledge.
REQ-012 waddrerr / raddrerr  output  1 each  address error, valid with wack / rack.
REQ-013 tx_data  output  32  TX_DATA register, zero-extended 8-bit value.
REQ-014 ctrl_cpol, ctrl_cpha, ctrl_order  output  1 each  CFG fields.
REQ-015 ctrl_scks  output  2  CFG SCK-divider select.
REQ-016 ctrl_slave_en  output  4  CFG slave-select enables.
REQ-017 ctrl_rd  output  1  CTRL read-mode bit.
REQ-018 start_op  output  1  one-cycle SPI start pulse.
REQ-019 rx_data  input  32  received data from SPI core.
REQ-020 busy  input  1  SPI core busy status.

Function
REQ-021 Map: 0x00 TX_DATA (RW, bits[7:0]); 0x04 RX_DATA (RO); 0x08 CFG (RW); 0x0C CTRL (RW); 0x10 STT (RO); full 32-bit address compare.
REQ-022 CFG layout: [0] cpol, [1] cpha, [2] order, [4:3] scks, [8:5] slave_en; other bits read 0.
REQ-023 CTRL layout: [0] start (write-1 trigger, reads 0), [1] rd; other bits read 0.
REQ-024 STT layout: [0] busy, live value of input busy at the read sample; other bits 0.
REQ-025 Write with wr_en=1: register updates at that clock edge; wack=1 in the following cycle for exactly one cycle.
REQ-026 Write to unmapped address, RX_DATA or STT: no state change; wack=1 and waddrerr=1 for that one cycle.
REQ-027 Read with rd_en=1: rdata registered at that edge, rack=1 next cycle for one cycle; rdata holds until the next read.
REQ-028 Read of unmapped address: rdata=0, rack=1, raddrerr=1 for one cycle.
REQ-029 Write to CTRL with wdata[0]=1 and busy=0: start_op=1 in the next cycle for exactly one cycle; with busy=1 the start is dropped (wack still asserted, no error).
REQ-030 Error flags SHALL be 0 whenever the corresponding ack is 0.
REQ-031 Read and write in the same cycle are independent; a read of the register being written returns the pre-write value.
REQ-032 Back-to-back requests each cycle SHALL each be acknowledged one cycle later.

Reset
REQ-033 reset=0 at a clock edge clears TX_DATA, CFG, CTRL, rdata, wack, rack, waddrerr, raddrerr and start_op to 0; a request coincident with reset is discarded.

Structure
REQ-034 Address constants, CFG/CTRL bit positions and a register-index enum belong in a shared package (spi_reg_pkg).
REQ-035 Single flat module; no sub-modules.

Verification
REQ-036 Write 0x0 data 0x000000A5 -> wack pulse, waddrerr=0, tx_data=0x000000A5; read 0x0 -> rdata=0x000000A5.
REQ-037 Write 0x8 data 0x000001FF -> cpol=cpha=order=1, scks=2'b11, slave_en=4'hF; read 0x8 -> 0x000001FF.
REQ-038 Write 0xC data 0x1, busy=0 -> start_op one-cycle pulse; read 0xC -> 0x00000000; repeat with busy=1 -> no pulse.
REQ-039 rx_data=0xDEADBEEF, read 0x4 -> rdata=0xDEADBEEF; busy=1, read 0x10 -> rdata=0x00000001.
REQ-040 Write 0xFF data 0x12345678 -> wack=1, waddrerr=1, no register changes; read 0xFF -> rdata=0, rack=1, raddrerr=1.
